// File: rtl/lsu_unit.sv
// Load/store unit: formats stores, extends loads, runs a req/gnt/rvalid handshake to data memory
// and raises misaligned, illegal-size and bus-timeout exceptions.
module lsu_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        store_done_o,
    output logic        exc_o,
    output logic [1:0]  exc_cause_o,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    localparam int unsigned CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // cnt_q equals (cycle index - 1) in REQ/WAIT, so the exception pulse lands TIMEOUT cycles
    // after the accept cycle.
    localparam int unsigned HitCnt = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

    localparam logic [1:0] CauseMisaligned = 2'b01;
    localparam logic [1:0] CauseIllegal    = 2'b10;
    localparam logic [1:0] CauseTimeout    = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e state_q, state_d;

    logic [31:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     load_data_q, load_data_d;
    logic            load_valid_q, load_valid_d;
    logic            store_done_q, store_done_d;
    logic            exc_q, exc_d;
    logic [1:0]      cause_q, cause_d;

    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        timeout_hit;
    logic [1:0]  size;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    assign accept = lsu_valid_i & (state_q == StIdle);
    assign size   = lsu_funct3_i[1:0];

    always_comb begin
        if (lsu_we_i) begin
            illegal = lsu_funct3_i[2] | (size == 2'b11);
        end else begin
            illegal = (size == 2'b11) | (lsu_funct3_i == 3'b110);
        end
        misaligned = ((size == 2'b01) & alu_result_i[0]) |
                     ((size == 2'b10) & (alu_result_i[1:0] != 2'b00));
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(HitCnt));

    // Bring the addressed byte/half down to lane 0; legal halves are even so one shift serves both.
    assign rdata_shifted = dmem_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_ext = {24'h000000, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_ext = {16'h0000, rdata_shifted[15:0]};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        store_done_d = 1'b0;
        exc_d        = 1'b0;
        cause_d      = cause_q;

        if (accept) begin
            cnt_d = '0;
        end else if (state_q != StIdle) begin
            cnt_d = cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d   = alu_result_i;
                    we_d     = lsu_we_i;
                    funct3_d = lsu_funct3_i;
                    if (illegal) begin
                        exc_d   = 1'b1;
                        cause_d = CauseIllegal;
                    end else if (misaligned) begin
                        exc_d   = 1'b1;
                        cause_d = CauseMisaligned;
                    end else begin
                        case (size)
                            2'b00: begin
                                be_d    = 4'b0001 << alu_result_i[1:0];
                                wdata_d = {4{store_data_i[7:0]}};
                            end
                            2'b01: begin
                                be_d    = 4'b0011 << {alu_result_i[1], 1'b0};
                                wdata_d = {2{store_data_i[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = store_data_i;
                            end
                        endcase
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (dmem_gnt_i && we_q) begin
                    store_done_d = 1'b1;
                    state_d      = StIdle;
                end else if (timeout_hit) begin
                    exc_d   = 1'b1;
                    cause_d = CauseTimeout;
                    state_d = StIdle;
                end else if (dmem_gnt_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dmem_rvalid_i) begin
                    load_valid_d = 1'b1;
                    load_data_d  = load_ext;
                    state_d      = StIdle;
                end else if (timeout_hit) begin
                    exc_d   = 1'b1;
                    cause_d = CauseTimeout;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            exc_q        <= 1'b0;
            cause_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            store_done_q <= store_done_d;
            exc_q        <= exc_d;
            cause_q      <= cause_d;
        end
    end

    assign lsu_ready_o  = (state_q == StIdle);
    assign dmem_req_o   = (state_q == StReq);
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign store_done_o = store_done_q;
    assign exc_o        = exc_q;
    assign exc_cause_o  = cause_q;

endmodule
